// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package im_loader_pkg;

  // Instruction word and instruction-memory address widths.
  localparam int INSTR_W = 17;
  localparam int ADDR_W  = 16;

  // Default frame start marker.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Loader FSM states, in frame order.
  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    W0,
    W1,
    W2,
    CHK,
    DONE,
    ERR
  } state_t;

  // Build one instruction word from its three frame bytes.
  function automatic logic [INSTR_W-1:0] assemble_word(input logic       b16,
                                                       input logic [7:0] hi,
                                                       input logic [7:0] lo);
    return {b16, hi, lo};
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the loader itself; the slave side is its environment
// (UART receiver, instruction memory, CPU).
interface im_loader_if;

  logic                                rx_rdy;
  logic [7:0]                          rx_data;
  logic                                wr_en;
  logic [im_loader_pkg::ADDR_W-1:0]    wr_addr;
  logic [im_loader_pkg::INSTR_W-1:0]   wr_data;
  logic                                cpu_hold;
  logic                                load_done;
  logic                                load_err;

  modport master (
    input  rx_rdy,
    input  rx_data,
    output wr_en,
    output wr_addr,
    output wr_data,
    output cpu_hold,
    output load_done,
    output load_err
  );

  modport slave (
    output rx_rdy,
    output rx_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  cpu_hold,
    input  load_done,
    input  load_err
  );

endinterface

// File: rtl/im_loader_timeout.sv
// Inter-byte idle counter. clear_i reloads it to zero, en_i lets it count,
// and expire_o fires once LIMIT idle cycles have elapsed since the last clear.
module im_loader_timeout #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(LIMIT + 1);
  // Last count value before expiry; the counter saturates here.
  localparam logic [TW-1:0] LAST_V = TW'(LIMIT - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Next count: reload on clear, otherwise count up while enabled and not yet saturated.
  always_comb begin
    // NOTE: default assignment first so every path assigns timer_d and no latch is inferred.
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (en_i && (timer_q != LAST_V)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Count register with asynchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A fresh byte in the same cycle wins over an expiry.
  assign expire_o = en_i && !clear_i && (timer_q == LAST_V);

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction memory loader. Parses a framed byte stream
// (SYNC, count, 3-byte words, XOR checksum), issues one write strobe per
// word and keeps the CPU held until a frame passes its checksum.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 8192,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  im_loader_if.master ld
);

  // Word counts above DEPTH are rejected; compare with one spare bit so
  // DEPTH itself may be 65536.
  localparam logic [16:0] DEPTH_V = 17'(DEPTH);

  state_t               state_q;
  logic [15:0]          count_q;
  logic [7:0]           chk_q;
  logic                 b16_q;
  logic [7:0]           hi_q;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [INSTR_W-1:0]   wr_data_q;
  logic                 cpu_hold_q;
  logic                 load_done_q;
  logic                 load_err_q;

  logic [15:0]          count_full;
  logic                 count_too_big;
  logic                 last_word;
  logic                 tmo_en;
  logic                 tmo_expire;

  // Full word count as it would be after latching the CNT_LO byte.
  assign count_full    = {count_q[15:8], ld.rx_data};
  assign count_too_big = {1'b0, count_full} > DEPTH_V;

  // The word being completed in W2 is the last one when the next index equals count.
  assign last_word = (wr_addr_q + ADDR_W'(1)) == count_q;

  // The idle timer only runs while a frame is in progress.
  assign tmo_en = state_q inside {CNT_HI, CNT_LO, W0, W1, W2, CHK};

  im_loader_timeout #(
    .LIMIT    (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (ld.rx_rdy),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // Frame parser FSM with registered write strobe and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      chk_q       <= '0;
      b16_q       <= 1'b0;
      hi_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      // The strobe lasts exactly one cycle; the address advances right after it.
      wr_en_q <= 1'b0;
      if (wr_en_q) begin
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end

      if (ld.rx_rdy) begin
        unique case (state_q)
          IDLE, DONE, ERR: begin
            // Only SYNC (re)starts a frame; every other byte is ignored here.
            if (ld.rx_data == SYNC_BYTE) begin
              state_q     <= CNT_HI;
              cpu_hold_q  <= 1'b1;
              load_done_q <= 1'b0;
              load_err_q  <= 1'b0;
              chk_q       <= '0;
              wr_addr_q   <= '0;
            end
          end

          CNT_HI: begin
            count_q[15:8] <= ld.rx_data;
            chk_q         <= chk_q ^ ld.rx_data;
            state_q       <= CNT_LO;
          end

          CNT_LO: begin
            count_q[7:0] <= ld.rx_data;
            chk_q        <= chk_q ^ ld.rx_data;
            if (count_too_big) begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end else if (count_full == 16'd0) begin
              state_q <= CHK;
            end else begin
              state_q <= W0;
            end
          end

          W0: begin
            chk_q <= chk_q ^ ld.rx_data;
            // Only bit 0 of the first word byte carries data; the pad bits must be clear.
            if (ld.rx_data[7:1] != 7'd0) begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end else begin
              b16_q   <= ld.rx_data[0];
              state_q <= W1;
            end
          end

          W1: begin
            hi_q    <= ld.rx_data;
            chk_q   <= chk_q ^ ld.rx_data;
            state_q <= W2;
          end

          W2: begin
            chk_q     <= chk_q ^ ld.rx_data;
            wr_en_q   <= 1'b1;
            wr_data_q <= assemble_word(b16_q, hi_q, ld.rx_data);
            state_q   <= last_word ? CHK : W0;
          end

          CHK: begin
            if (ld.rx_data == chk_q) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end else if (tmo_expire) begin
        // The sender stalled inside a frame; cpu_hold stays asserted.
        state_q    <= ERR;
        load_err_q <= 1'b1;
      end
    end
  end

  assign ld.wr_en     = wr_en_q;
  assign ld.wr_addr   = wr_addr_q;
  assign ld.wr_data   = wr_data_q;
  assign ld.cpu_hold  = cpu_hold_q;
  assign ld.load_done = load_done_q;
  assign ld.load_err  = load_err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: frames are parsed by a reference model
// into expected writes and an expected outcome; a monitor compares every
// write strobe against the scoreboard queue.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int DEPTH = 8192;
  localparam int TMO   = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  im_loader_if bus();

  im_loader #(
    .DEPTH     (DEPTH),
    .TIMEOUT   (TMO),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ld  (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [16:0] data;
    int          cyc;
  } exp_wr_t;

  typedef struct {
    logic [15:0] addr;
    logic [16:0] data;
    int          idx;
  } mdl_wr_t;

  exp_wr_t    exp_q[$];
  mdl_wr_t    m_wr[$];
  logic [7:0] frm[$];
  bit         m_ok;
  bit         m_trunc;
  int         m_len;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: interpret frm by the frame rules; trunc>0 means only that many bytes are sent.
  task automatic run_model(input int trunc);
    int         cnt;
    logic [7:0] x;
    mdl_wr_t    w_ent;
    m_wr.delete();
    m_ok    = 1'b0;
    m_trunc = 1'b0;
    m_len   = -1;
    cnt     = int'({frm[1], frm[2]});
    if (cnt > DEPTH) begin
      m_len = 3;
    end else begin
      for (int w = 0; w < cnt && m_len < 0 && (3 + 3*w + 2) < frm.size(); w++) begin
        int i;
        i = 3 + 3*w;
        if (frm[i][7:1] != 7'd0) begin
          m_len = i + 1;
        end else begin
          w_ent.addr = 16'(w);
          w_ent.data = {frm[i][0], frm[i+1], frm[i+2]};
          w_ent.idx  = i + 2;
          m_wr.push_back(w_ent);
        end
      end
      if (m_len < 0) begin
        if (frm.size() < 4 + 3*cnt) begin
          m_len   = frm.size();
          m_trunc = 1'b1;
        end else begin
          x = 8'h00;
          for (int i = 1; i < 3 + 3*cnt; i++) x ^= frm[i];
          m_ok  = (frm[3 + 3*cnt] == x);
          m_len = 4 + 3*cnt;
        end
      end
    end
    if (trunc > 0 && trunc < m_len) begin
      m_len   = trunc;
      m_ok    = 1'b0;
      m_trunc = 1'b1;
      while (m_wr.size() > 0 && m_wr[$].idx >= trunc) void'(m_wr.pop_back());
    end
  endtask

  // Send one byte; if it completes a modelled word, expect the write on the following cycle.
  task automatic send_byte(input logic [7:0] b, input int idx);
    exp_wr_t e;
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    foreach (m_wr[k]) begin
      if (idx >= 0 && m_wr[k].idx == idx) begin
        e.addr = m_wr[k].addr;
        e.data = m_wr[k].data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'hA5;  // idle bus shows SYNC so an unqualified capture would be caught
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int trunc);
    run_model(trunc);
    for (int i = 0; i < m_len; i++) send_byte(frm[i], i);
    repeat (m_trunc ? TMO + 20 : 4) @(negedge clk);
    check({tag, "_load_done"}, 32'(bus.load_done), 32'(m_ok));
    check({tag, "_load_err"},  32'(bus.load_err),  32'(!m_ok));
    check({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'(!m_ok));
    check({tag, "_wr_addr"},   32'(bus.wr_addr),   32'(m_wr.size()));
    check({tag, "_pending"},   32'(exp_q.size()),  32'd0);
    exp_q.delete();
  endtask

  // Random frame: mode 0 good, 1 bad checksum, 2 bad pad bits, 3 truncated.
  task automatic build_random(input int cnt, input int mode, output int trunc);
    logic [16:0] d;
    logic [7:0]  b0;
    logic [7:0]  x;
    int          pw;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(8'(cnt >> 8));
    frm.push_back(8'(cnt));
    pw = (cnt > 0) ? int'($urandom_range(0, cnt - 1)) : 0;
    for (int w = 0; w < cnt; w++) begin
      d  = 17'($urandom);
      b0 = {7'd0, d[16]};
      if (mode == 2 && w == pw) b0[7:1] = 7'($urandom_range(1, 127));
      frm.push_back(b0);
      frm.push_back(d[15:8]);
      frm.push_back(d[7:0]);
    end
    x = 8'h00;
    for (int i = 1; i < frm.size(); i++) x ^= frm[i];
    if (mode == 1) x ^= 8'(1 << $urandom_range(0, 7));
    frm.push_back(x);
    trunc = (mode == 3) ? int'($urandom_range(1, frm.size() - 1)) : 0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard, in address, data and cycle.
  initial begin : monitor
    bit      prev_en;
    exp_wr_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.wr_en === 1'b1) begin
        check("wr_en_back_to_back", 32'(prev_en), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(e.data));
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_en = bus.wr_en;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test expected finish within budget");
    $fatal(1);
  end

  initial begin : stimulus
    int trunc;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'hA5;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en",     32'(bus.wr_en),     32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    check("rst_wr_data",   32'(bus.wr_data),   32'd0);
    check("rst_cpu_hold",  32'(bus.cpu_hold),  32'd0);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_load_err",  32'(bus.load_err),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cpu_hold", 32'(bus.cpu_hold), 32'd0);

    // Directed frames.
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'hFF, 8'h9A};
    run_frame("good2", 0);
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'hFF, 8'h9B};
    run_frame("badchk", 0);
    frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03};
    run_frame("badpad", 0);
    frm = '{8'hA5, 8'h20, 8'h01};
    run_frame("cnt8193", 0);
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("cnt0", 0);
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'hFF, 8'h9A};
    run_frame("stall_w1", 5);
    frm = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'hFF, 8'hFF};
    run_frame("cnt8192", 0);

    // Leading garbage is ignored, then a frame loads.
    send_byte(8'h11, -1);
    send_byte(8'h22, -1);
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'hFF, 8'h9A};
    run_frame("after_garbage", 0);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      int cnt;
      int mode;
      cnt  = $urandom_range(0, 6);
      mode = $urandom_range(0, 3);
      if (mode == 2 && cnt == 0) cnt = 1;
      build_random(cnt, mode, trunc);
      run_frame($sformatf("rand%0d_m%0d", n, mode), trunc);
    end

    // Reset in the middle of a word aborts everything.
    frm = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'hFF, 8'h9A};
    for (int i = 0; i < 5; i++) send_byte(frm[i], -1);
    check("pre_rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_en",     32'(bus.wr_en),     32'd0);
    check("mid_rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    check("mid_rst_wr_data",   32'(bus.wr_data),   32'd0);
    check("mid_rst_cpu_hold",  32'(bus.cpu_hold),  32'd0);
    check("mid_rst_load_done", 32'(bus.load_done), 32'd0);
    check("mid_rst_load_err",  32'(bus.load_err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_frame("after_rst", 0);

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time writer for the 17-bit instruction memory: consumes a framed byte stream (from the UART receiver) and emits single-cycle write strobes into the instruction memory write port.
- Holds the CPU in stall while loading; releases it only after a frame passes its checksum.
- Sits between the UART rx and the instruction memory, in parallel with the CPU fetch path, which is read-only.

Parameters:
- DEPTH, 8192, number of instruction words; word counts above this are rejected.
- TIMEOUT, 1000000, maximum idle clk cycles between bytes inside a frame before abort.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_rdy  in  1  one-cycle pulse: rx_data valid.
- rx_data  in  8  received byte.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  16  write address.
- wr_data  out  17  write data.
- cpu_hold  out  1  stall/reset request to CPU while loading or on error.
- load_done  out  1  frame loaded and checksum OK.
- load_err  out  1  frame aborted (bad count, bad pad bits, checksum, timeout).

Behaviour:
- Reset is asynchronous, active-high, on clk and rst as named above. Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, load_done=0, load_err=0, count=0, chk=0, timer=0.
- Frame format, big-endian: SYNC, CNT_HI, CNT_LO, then CNT words of 3 bytes each (B0 carries bit 16 in bit 0, with bits 7:1 required to be 0; B1 = bits 15:8; B2 = bits 7:0), then CHK. CHK = XOR of all bytes after SYNC, up to and excluding CHK.
- States:
  - IDLE: on rx_rdy with rx_data==SYNC, go to CNT_HI, set cpu_hold=1, clear load_done/load_err, chk=0, wr_addr=0. Other bytes are ignored.
  - CNT_HI: latch count[15:8], then go to CNT_LO.
  - CNT_LO: latch count[7:0]. If count>DEPTH, go to ERR. If count==0, go to CHK. Otherwise go to W0.
  - W0: if rx_data[7:1]!=0, go to ERR. Otherwise latch bit 16 and go to W1.
  - W1: latch bits 15:8, then go to W2.
  - W2: latch bits 7:0. On the next cycle wr_en=1 with wr_data = assembled word and wr_addr = current index. The cycle after the strobe, wr_addr increments. When the index reaches count, go to CHK; otherwise go to W0.
  - CHK: if rx_data==chk, go to DONE; otherwise go to ERR.
  - DONE: load_done=1, cpu_hold=0. SYNC restarts the frame (same as IDLE).
  - ERR: load_err=1, cpu_hold stays 1, no further writes. SYNC restarts the frame.
- chk is updated with every byte accepted in CNT_HI, CNT_LO, W0, W1 and W2.
- wr_en is registered. Its latency is 1 cycle after the W2 byte's rx_rdy. It is never high for two consecutive cycles; bytes arrive at most once every 2 cycles.
- Timeout: timer resets on each rx_rdy and counts in CNT_HI..CHK. At TIMEOUT it goes to ERR. The timer is inactive in IDLE, DONE and ERR.
- Last word: the address of the final write is count-1. After the final write, wr_addr holds count; it does not wrap.
- rx_rdy coinciding with the cycle of a pending wr_en is legal: the byte is consumed and the write still issues.
- Mid-frame reset aborts immediately. Partial words are never written; cpu_hold drops to 0.

Decomposition:
- Package im_loader_pkg holds:
  - state enum typedef (IDLE, CNT_HI, CNT_LO, W0, W1, W2, CHK, DONE, ERR);
  - INSTR_W=17 and ADDR_W=16 constants;
  - default SYNC_BYTE.
- Sub-module: im_loader_timeout, a loadable idle counter with clear/enable/expire ports. Everything else stays in one FSM module.

Test Plan:
- Count 2, words 17'h1_2345 and 17'h0_00FF. Bytes: A5 00 02 01 23 45 00 00 FF, CHK = 00^02^01^23^45^00^00^FF = 0x9A. Required: wr_en pulses at addr 0 (data 0x12345) and addr 1 (data 0x000FF); load_done=1; cpu_hold=0.
- Same frame with CHK=0x9B -> both writes occur, then load_err=1, cpu_hold=1, load_done=0.
- A5 00 01 02 .. -> ERR right after the 02 byte (bad pad bit); no wr_en.
- A5 20 01 (count 8193 > DEPTH) -> ERR; no writes. A5 00 00 00 -> DONE with zero writes.
- TIMEOUT=50, frame stalled after the W1 byte for 50 cycles -> load_err=1; no partial write.
- Leading garbage 11 22 then a valid frame -> garbage ignored in IDLE, frame loads. rst asserted mid-word -> outputs at reset values, and a following valid frame loads from addr 0.
